// File: rtl/riscv_regfile_mp_pkg.sv
// riscv_regfile_mp_pkg: sweep FSM states and legal register-count constants shared by the register file.
package riscv_regfile_mp_pkg;
  typedef enum logic {IDLE, SWEEP} sweep_state_e;
  localparam int NUM_REGS_RV32E = 16;
  localparam int NUM_REGS_RV32I = 32;
endpackage

// File: rtl/riscv_regfile_mp_if.sv
// riscv_regfile_mp_if: read, write-back, mark and sweep signals of the register file bundled for benches and wrappers.
interface riscv_regfile_mp_if import riscv_regfile_mp_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = NUM_REGS_RV32I,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  localparam int AW = $clog2(NUM_REGS)
);
  logic [NUM_RD*AW-1:0] rd_addr_i;
  logic [NUM_RD*XLEN-1:0] rd_data_o;
  logic [NUM_RD-1:0] rd_busy_o;
  logic [NUM_WR-1:0] wr_en_i;
  logic [NUM_WR*AW-1:0] wr_addr_i;
  logic [NUM_WR*XLEN-1:0] wr_data_i;
  logic mark_en_i;
  logic [AW-1:0] mark_addr_i;
  logic clr_req_i;
  logic clr_busy_o;
  logic clr_done_o;
  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, mark_en_i, mark_addr_i, clr_req_i,
    input rd_data_o, rd_busy_o, clr_busy_o, clr_done_o
  );
  modport slave (
    input rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, mark_en_i, mark_addr_i, clr_req_i,
    output rd_data_o, rd_busy_o, clr_busy_o, clr_done_o
  );
endinterface

// File: rtl/riscv_reg_scoreboard.sv
// riscv_reg_scoreboard: one pending-producer bit per register; set by ID marks, cleared by write-back.
module riscv_reg_scoreboard import riscv_regfile_mp_pkg::*; #(
  parameter int NUM_REGS = NUM_REGS_RV32I,
  parameter int NUM_WR = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input logic clk_i,
  input logic rst_ni,
  input logic i_clr_all,
  input logic [NUM_WR-1:0] i_wr_en,
  input logic [NUM_WR*AW-1:0] i_wr_addr,
  input logic i_mark_en,
  input logic [AW-1:0] i_mark_addr,
  output logic [NUM_REGS-1:0] o_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int p = 0; p < NUM_WR; p++) if (i_wr_en[p]) w_clr[i_wr_addr[p*AW +: AW]] = 1'b1;
    if (i_mark_en) w_set[i_mark_addr] = 1'b1;
  end
  // set is applied after clear so a same-cycle mark keeps the register busy; x0 never goes busy
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_busy <= '0;
    else if (i_clr_all) r_busy <= '0;
    else r_busy <= ((r_busy & ~w_clr) | w_set) & {{(NUM_REGS-1){1'b1}}, 1'b0};
  assign o_busy = r_busy;
endmodule

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: multi-port RISC-V register file with optional WB bypass, busy scoreboard
// and a zeroization sweep that clears x1..x(N-1) one register per cycle.
module riscv_regfile_mp import riscv_regfile_mp_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = NUM_REGS_RV32I,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS_EN = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input logic clk_i,
  input logic rst_ni,
  input logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD*XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0] rd_busy_o,
  input logic [NUM_WR-1:0] wr_en_i,
  input logic [NUM_WR*AW-1:0] wr_addr_i,
  input logic [NUM_WR*XLEN-1:0] wr_data_i,
  input logic mark_en_i,
  input logic [AW-1:0] mark_addr_i,
  input logic clr_req_i,
  output logic clr_busy_o,
  output logic clr_done_o
);
  sweep_state_e r_state;
  logic [AW-1:0] r_idx;
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_WR-1:0] w_wen;
  logic w_sweep;
  logic w_start;
  assign w_sweep = r_state == SWEEP;
  assign w_start = !w_sweep && clr_req_i;
  // qualified writes: x0 and anything arriving during a sweep are dropped
  always_comb begin
    w_wen = '0;
    for (int p = 0; p < NUM_WR; p++) w_wen[p] = wr_en_i[p] && wr_addr_i[p*AW +: AW] != '0 && !w_sweep;
  end
  riscv_reg_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_WR(NUM_WR)) u_sb (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .i_clr_all(w_start),
    .i_wr_en(w_wen),
    .i_wr_addr(wr_addr_i),
    .i_mark_en(mark_en_i && !w_sweep),
    .i_mark_addr(mark_addr_i),
    .o_busy(w_busy)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    else if (w_sweep) r_regs[r_idx] <= '0;
    else for (int p = 0; p < NUM_WR; p++) if (w_wen[p]) r_regs[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_idx <= '0;
      clr_busy_o <= 1'b0;
      clr_done_o <= 1'b0;
    end else begin
      clr_done_o <= 1'b0;
      if (!w_sweep) begin
        if (clr_req_i) begin
          r_state <= SWEEP;
          r_idx <= AW'(1);
          clr_busy_o <= 1'b1;
        end
      end else if (r_idx == AW'(NUM_REGS-1)) begin
        r_state <= IDLE;
        r_idx <= '0;
        clr_busy_o <= 1'b0;
        clr_done_o <= 1'b1;
      end else r_idx <= r_idx + 1'b1;
    end
  // returns {bypass_hit, data}; the highest-index matching write port wins
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
    logic [XLEN:0] v;
    v = {1'b0, r_regs[a]};
    for (int p = 0; p < NUM_WR; p++)
      if (BYPASS_EN != 0 && w_wen[p] && wr_addr_i[p*AW +: AW] == a) v = {1'b1, wr_data_i[p*XLEN +: XLEN]};
    return a == '0 ? '0 : v;
  endfunction
  always_comb begin
    logic [XLEN:0] w_rp;
    w_rp = '0;
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_rp = read_port(rd_addr_i[k*AW +: AW]);
      rd_data_o[k*XLEN +: XLEN] = w_rp[XLEN-1:0];
      rd_busy_o[k] = w_busy[rd_addr_i[k*AW +: AW]] && !w_rp[XLEN];
    end
  end
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// tb_riscv_regfile_mp: randomized and directed checks of three register-file configurations
// (2W bypass, 2W no-bypass sharing the same stimulus, and a 16-register RV32E instance).
module tb_riscv_regfile_mp;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  riscv_regfile_mp_if #(.NUM_WR(2)) ifa();
  riscv_regfile_mp_if #(.NUM_REGS(16), .NUM_WR(1)) ifc();
  logic [63:0] b_rd_data;
  logic [1:0] b_rd_busy;
  logic b_clr_busy, b_clr_done;

  riscv_regfile_mp #(.NUM_WR(2), .BYPASS_EN(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .rd_addr_i(ifa.rd_addr_i), .rd_data_o(ifa.rd_data_o), .rd_busy_o(ifa.rd_busy_o),
    .wr_en_i(ifa.wr_en_i), .wr_addr_i(ifa.wr_addr_i), .wr_data_i(ifa.wr_data_i), .mark_en_i(ifa.mark_en_i),
    .mark_addr_i(ifa.mark_addr_i), .clr_req_i(ifa.clr_req_i), .clr_busy_o(ifa.clr_busy_o), .clr_done_o(ifa.clr_done_o));
  riscv_regfile_mp #(.NUM_WR(2), .BYPASS_EN(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .rd_addr_i(ifa.rd_addr_i), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
    .wr_en_i(ifa.wr_en_i), .wr_addr_i(ifa.wr_addr_i), .wr_data_i(ifa.wr_data_i), .mark_en_i(ifa.mark_en_i),
    .mark_addr_i(ifa.mark_addr_i), .clr_req_i(ifa.clr_req_i), .clr_busy_o(b_clr_busy), .clr_done_o(b_clr_done));
  riscv_regfile_mp #(.NUM_REGS(16), .NUM_WR(1), .BYPASS_EN(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .rd_addr_i(ifc.rd_addr_i), .rd_data_o(ifc.rd_data_o), .rd_busy_o(ifc.rd_busy_o),
    .wr_en_i(ifc.wr_en_i), .wr_addr_i(ifc.wr_addr_i), .wr_data_i(ifc.wr_data_i), .mark_en_i(ifc.mark_en_i),
    .mark_addr_i(ifc.mark_addr_i), .clr_req_i(ifc.clr_req_i), .clr_busy_o(ifc.clr_busy_o), .clr_done_o(ifc.clr_done_o));

  // reference state: index 0 = 32-register config (dut_a/dut_b), index 1 = 16-register config (dut_c)
  logic [31:0] m_regs [2][32];
  bit m_busy [2][32];
  bit m_sweep [2];
  bit m_done [2];
  int m_next [2];
  int m_n [2] = '{32, 16};

  function automatic bit cur_we(input int i, input int p);
    if (i == 0) return ifa.wr_en_i[p];
    return p == 0 && ifc.wr_en_i[0];
  endfunction
  function automatic int cur_wa(input int i, input int p);
    return i == 0 ? int'(ifa.wr_addr_i[p*5 +: 5]) : int'(ifc.wr_addr_i);
  endfunction
  function automatic logic [31:0] cur_wd(input int i, input int p);
    return i == 0 ? ifa.wr_data_i[p*32 +: 32] : ifc.wr_data_i;
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input bit byp, input int ra);
    logic [31:0] v;
    v = m_regs[i][ra];
    if (ra == 0) return 32'h0;
    if (byp && !m_sweep[i])
      for (int p = 0; p < 2; p++) if (cur_we(i, p) && cur_wa(i, p) == ra) v = cur_wd(i, p);
    return v;
  endfunction
  function automatic bit exp_busy(input int i, input bit byp, input int ra);
    if (ra == 0) return 1'b0;
    if (byp && !m_sweep[i])
      for (int p = 0; p < 2; p++) if (cur_we(i, p) && cur_wa(i, p) == ra) return 1'b0;
    return m_busy[i][ra];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[i][r] = 32'h0;
        m_busy[i][r] = 1'b0;
      end
      m_sweep[i] = 1'b0;
      m_done[i] = 1'b0;
      m_next[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit me, cr;
    int ma;
    me = i == 0 ? ifa.mark_en_i : ifc.mark_en_i;
    ma = i == 0 ? int'(ifa.mark_addr_i) : int'(ifc.mark_addr_i);
    cr = i == 0 ? ifa.clr_req_i : ifc.clr_req_i;
    if (m_sweep[i]) begin
      m_regs[i][m_next[i]] = 32'h0;
      m_next[i]++;
      m_done[i] = m_next[i] == m_n[i];
      if (m_done[i]) m_sweep[i] = 1'b0;
    end else begin
      m_done[i] = 1'b0;
      for (int p = 0; p < 2; p++)
        if (cur_we(i, p) && cur_wa(i, p) != 0) begin
          m_regs[i][cur_wa(i, p)] = cur_wd(i, p);
          m_busy[i][cur_wa(i, p)] = 1'b0;
        end
      if (me && ma != 0) m_busy[i][ma] = 1'b1;
      if (cr) begin
        for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
        m_sweep[i] = 1'b1;
        m_next[i] = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_ni) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic idle();
    ifa.wr_en_i = '0; ifa.wr_addr_i = '0; ifa.wr_data_i = '0;
    ifa.mark_en_i = 1'b0; ifa.mark_addr_i = '0; ifa.clr_req_i = 1'b0;
    ifc.wr_en_i = '0; ifc.wr_addr_i = '0; ifc.wr_data_i = '0;
    ifc.mark_en_i = 1'b0; ifc.mark_addr_i = '0; ifc.clr_req_i = 1'b0;
  endtask

  function automatic int pick(input int n);
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n-1)) : int'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    model_reset();
    idle();
    ifa.rd_addr_i = {5'd5, 5'd0};
    ifc.rd_addr_i = {4'd15, 4'd3};
    tick();
    checks++; if (ifa.clr_busy_o !== 1'b0 || ifa.clr_done_o !== 1'b0) begin errors++; $display("FAIL reset_a_flags got=%b%b exp=00", ifa.clr_busy_o, ifa.clr_done_o); end
    checks++; if (ifa.rd_data_o !== 64'h0) begin errors++; $display("FAIL reset_a_data got=%h exp=0", ifa.rd_data_o); end
    checks++; if (ifa.rd_busy_o !== 2'b00) begin errors++; $display("FAIL reset_a_busy got=%b exp=00", ifa.rd_busy_o); end
    checks++; if (ifc.clr_busy_o !== 1'b0 || ifc.rd_data_o !== 64'h0) begin errors++; $display("FAIL reset_c got=%b/%h exp=0/0", ifc.clr_busy_o, ifc.rd_data_o); end
    rst_ni = 1'b1;
    tick();
    checks++; if (b_clr_busy !== 1'b0 || b_clr_done !== 1'b0) begin errors++; $display("FAIL reset_b_flags got=%b%b exp=00", b_clr_busy, b_clr_done); end
  endtask

  task automatic test_write();
    idle();
    ifa.wr_en_i = 2'b01; ifa.wr_addr_i = {5'd0, 5'd5}; ifa.wr_data_i = {32'h0, 32'hDEADBEEF};
    ifa.rd_addr_i = {5'd5, 5'd0};
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_data_o[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_read_a got=%h exp=deadbeef", ifa.rd_data_o[63:32]); end
    checks++; if (b_rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL x5_read_b got=%h exp=deadbeef", b_rd_data[63:32]); end
    ifa.wr_en_i = 2'b01; ifa.wr_addr_i = '0; ifa.wr_data_i = {32'h0, 32'h1234};
    ifa.rd_addr_i = '0;
    #2;
    checks++; if (ifa.rd_data_o[31:0] !== 32'h0) begin errors++; $display("FAIL x0_bypass got=%h exp=0", ifa.rd_data_o[31:0]); end
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_data_o !== 64'h0 || b_rd_data !== 64'h0) begin errors++; $display("FAIL x0_read got=%h/%h exp=0", ifa.rd_data_o, b_rd_data); end
  endtask

  task automatic test_dual_write();
    idle();
    ifa.wr_en_i = 2'b01; ifa.wr_addr_i = {5'd0, 5'd7}; ifa.wr_data_i = {32'h0, 32'h55};
    tick();
    ifa.wr_en_i = 2'b11; ifa.wr_addr_i = {5'd7, 5'd7}; ifa.wr_data_i = {32'h22, 32'h11};
    ifa.rd_addr_i = {5'd7, 5'd7};
    #2;
    checks++; if (ifa.rd_data_o[31:0] !== 32'h22) begin errors++; $display("FAIL dual_bypass_a got=%h exp=22", ifa.rd_data_o[31:0]); end
    checks++; if (b_rd_data[31:0] !== 32'h55) begin errors++; $display("FAIL dual_nobypass_b got=%h exp=55", b_rd_data[31:0]); end
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_data_o[63:32] !== 32'h22) begin errors++; $display("FAIL dual_after_a got=%h exp=22", ifa.rd_data_o[63:32]); end
    checks++; if (b_rd_data[63:32] !== 32'h22) begin errors++; $display("FAIL dual_after_b got=%h exp=22", b_rd_data[63:32]); end
  endtask

  task automatic test_busy();
    idle();
    ifa.rd_addr_i = {5'd9, 5'd9};
    ifa.mark_en_i = 1'b1; ifa.mark_addr_i = 5'd9;
    #2;
    checks++; if (ifa.rd_busy_o[0] !== 1'b0) begin errors++; $display("FAIL busy_before_mark got=%b exp=0", ifa.rd_busy_o[0]); end
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_busy_o !== 2'b11 || b_rd_busy !== 2'b11) begin errors++; $display("FAIL busy_after_mark got=%b/%b exp=11", ifa.rd_busy_o, b_rd_busy); end
    ifa.mark_en_i = 1'b1; ifa.mark_addr_i = 5'd9;
    ifa.wr_en_i = 2'b01; ifa.wr_addr_i = {5'd0, 5'd9}; ifa.wr_data_i = {32'h0, 32'h99};
    #2;
    checks++; if (ifa.rd_busy_o[0] !== 1'b0 || ifa.rd_data_o[31:0] !== 32'h99) begin errors++; $display("FAIL busy_mask_a got=%b/%h exp=0/99", ifa.rd_busy_o[0], ifa.rd_data_o[31:0]); end
    checks++; if (b_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_nomask_b got=%b exp=1", b_rd_busy[0]); end
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_busy_o[0] !== 1'b1 || b_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL busy_set_wins got=%b/%b exp=1", ifa.rd_busy_o[0], b_rd_busy[0]); end
    ifa.wr_en_i = 2'b10; ifa.wr_addr_i = {5'd9, 5'd0}; ifa.wr_data_i = {32'hAB, 32'h0};
    tick();
    idle();
    #2;
    checks++; if (ifa.rd_busy_o !== 2'b00 || b_rd_busy !== 2'b00) begin errors++; $display("FAIL busy_cleared got=%b/%b exp=00", ifa.rd_busy_o, b_rd_busy); end
  endtask

  task automatic test_random();
    int ra;
    for (int c = 0; c < 400; c++) begin
      ifa.wr_en_i = 2'($urandom);
      ifa.wr_addr_i = {5'(pick(32)), 5'(pick(32))};
      ifa.wr_data_i = {$urandom, $urandom};
      ifa.mark_en_i = $urandom_range(0, 2) == 0;
      ifa.mark_addr_i = 5'(pick(32));
      ifa.clr_req_i = $urandom_range(0, 79) == 0;
      ifa.rd_addr_i = {5'(pick(32)), 5'(pick(32))};
      ifc.wr_en_i = 1'($urandom);
      ifc.wr_addr_i = 4'(pick(16));
      ifc.wr_data_i = $urandom;
      ifc.mark_en_i = $urandom_range(0, 2) == 0;
      ifc.mark_addr_i = 4'(pick(16));
      ifc.clr_req_i = $urandom_range(0, 59) == 0;
      ifc.rd_addr_i = {4'(pick(16)), 4'(pick(16))};
      #2;
      for (int k = 0; k < 2; k++) begin
        ra = int'(ifa.rd_addr_i[k*5 +: 5]);
        checks++; if (ifa.rd_data_o[k*32 +: 32] !== exp_rd(0, 1, ra)) begin errors++; $display("FAIL rand_a_data c%0d p%0d x%0d got=%h exp=%h", c, k, ra, ifa.rd_data_o[k*32 +: 32], exp_rd(0, 1, ra)); end
        checks++; if (b_rd_data[k*32 +: 32] !== exp_rd(0, 0, ra)) begin errors++; $display("FAIL rand_b_data c%0d p%0d x%0d got=%h exp=%h", c, k, ra, b_rd_data[k*32 +: 32], exp_rd(0, 0, ra)); end
        checks++; if (ifa.rd_busy_o[k] !== exp_busy(0, 1, ra)) begin errors++; $display("FAIL rand_a_busy c%0d p%0d x%0d got=%b exp=%b", c, k, ra, ifa.rd_busy_o[k], exp_busy(0, 1, ra)); end
        checks++; if (b_rd_busy[k] !== exp_busy(0, 0, ra)) begin errors++; $display("FAIL rand_b_busy c%0d p%0d x%0d got=%b exp=%b", c, k, ra, b_rd_busy[k], exp_busy(0, 0, ra)); end
        ra = int'(ifc.rd_addr_i[k*4 +: 4]);
        checks++; if (ifc.rd_data_o[k*32 +: 32] !== exp_rd(1, 1, ra)) begin errors++; $display("FAIL rand_c_data c%0d p%0d x%0d got=%h exp=%h", c, k, ra, ifc.rd_data_o[k*32 +: 32], exp_rd(1, 1, ra)); end
        checks++; if (ifc.rd_busy_o[k] !== exp_busy(1, 1, ra)) begin errors++; $display("FAIL rand_c_busy c%0d p%0d x%0d got=%b exp=%b", c, k, ra, ifc.rd_busy_o[k], exp_busy(1, 1, ra)); end
      end
      checks++; if ({ifa.clr_busy_o, ifa.clr_done_o, b_clr_busy, b_clr_done} !== {m_sweep[0], m_done[0], m_sweep[0], m_done[0]}) begin errors++; $display("FAIL rand_ab_flags c%0d got=%b%b%b%b exp=%b%b", c, ifa.clr_busy_o, ifa.clr_done_o, b_clr_busy, b_clr_done, m_sweep[0], m_done[0]); end
      checks++; if ({ifc.clr_busy_o, ifc.clr_done_o} !== {m_sweep[1], m_done[1]}) begin errors++; $display("FAIL rand_c_flags c%0d got=%b%b exp=%b%b", c, ifc.clr_busy_o, ifc.clr_done_o, m_sweep[1], m_done[1]); end
      tick();
    end
    idle();
    for (int w = 0; w < 40 && (m_sweep[0] || m_sweep[1]); w++) tick();
    tick();
  endtask

  task automatic test_sweep();
    int n;
    idle();
    for (int r = 1; r < 32; r++) begin
      ifa.wr_en_i = 2'b10; ifa.wr_addr_i = {5'(r), 5'd0}; ifa.wr_data_i = {32'hFFFFFFFF, 32'h0};
      ifa.mark_en_i = 1'b1; ifa.mark_addr_i = 5'(r);
      tick();
    end
    idle();
    ifa.rd_addr_i = {5'd31, 5'd1};
    #2;
    checks++; if (ifa.rd_data_o !== 64'hFFFFFFFF_FFFFFFFF || ifa.rd_busy_o !== 2'b11) begin errors++; $display("FAIL fill got=%h/%b exp=all ones/11", ifa.rd_data_o, ifa.rd_busy_o); end
    ifa.clr_req_i = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (n < 100) begin
        ifa.wr_en_i = 2'b11;
        ifa.wr_addr_i = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
        ifa.wr_data_i = {$urandom | 32'h1, $urandom | 32'h1};
        ifa.mark_en_i = 1'b1; ifa.mark_addr_i = 5'($urandom_range(1, 31));
        ifa.clr_req_i = 1'b1;
        ifa.rd_addr_i = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
        #1;
        if (!ifa.clr_busy_o) break;
        n++;
        checks++; if (ifa.clr_done_o !== 1'b0) begin errors++; $display("FAIL sweep_early_done s%0d n%0d got=1 exp=0", s, n); end
        checks++; if (ifa.rd_data_o[31:0] !== exp_rd(0, 1, int'(ifa.rd_addr_i[4:0]))) begin errors++; $display("FAIL sweep_read s%0d n%0d got=%h exp=%h", s, n, ifa.rd_data_o[31:0], exp_rd(0, 1, int'(ifa.rd_addr_i[4:0]))); end
        tick();
      end
      checks++; if (n != 31) begin errors++; $display("FAIL sweep_len s%0d got=%0d exp=31", s, n); end
      idle();
      ifa.clr_req_i = s == 0;
      #1;
      checks++; if (ifa.clr_done_o !== 1'b1 || b_clr_done !== 1'b1) begin errors++; $display("FAIL sweep_done s%0d got=%b/%b exp=1", s, ifa.clr_done_o, b_clr_done); end
      tick();
      ifa.clr_req_i = 1'b0;
    end
    #1;
    checks++; if (ifa.clr_done_o !== 1'b0 || ifa.clr_busy_o !== 1'b0) begin errors++; $display("FAIL sweep_done_pulse got=%b%b exp=00", ifa.clr_busy_o, ifa.clr_done_o); end
    for (int r = 0; r < 32; r++) begin
      ifa.rd_addr_i = {5'(r), 5'(r)};
      #1;
      checks++; if (ifa.rd_data_o !== 64'h0 || b_rd_data !== 64'h0 || ifa.rd_busy_o !== 2'b00) begin errors++; $display("FAIL sweep_zero x%0d got=%h/%h/%b exp=0", r, ifa.rd_data_o, b_rd_data, ifa.rd_busy_o); end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    ifa.wr_en_i = 2'b01; ifa.wr_addr_i = {5'd0, 5'd20}; ifa.wr_data_i = {32'h0, 32'hA5A50020};
    tick();
    idle();
    ifa.mark_en_i = 1'b1; ifa.mark_addr_i = 5'd20;
    tick();
    idle();
    ifa.clr_req_i = 1'b1;
    tick();
    ifa.clr_req_i = 1'b0;
    repeat (9) tick();
    ifa.rd_addr_i = {5'd3, 5'd20};
    #1;
    checks++; if (ifa.rd_data_o[31:0] !== 32'hA5A50020 || ifa.clr_busy_o !== 1'b1) begin errors++; $display("FAIL pre_reset got=%h/%b exp=a5a50020/1", ifa.rd_data_o[31:0], ifa.clr_busy_o); end
    rst_ni = 1'b0;
    #1;
    model_reset();
    checks++; if (ifa.clr_busy_o !== 1'b0 || ifa.clr_done_o !== 1'b0 || b_clr_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got=%b%b%b exp=000", ifa.clr_busy_o, ifa.clr_done_o, b_clr_busy); end
    checks++; if (ifa.rd_data_o !== 64'h0 || b_rd_data !== 64'h0 || ifa.rd_busy_o !== 2'b00) begin errors++; $display("FAIL mid_reset_data got=%h/%h/%b exp=0", ifa.rd_data_o, b_rd_data, ifa.rd_busy_o); end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    checks++; if (ifa.clr_done_o !== 1'b0 || ifa.clr_busy_o !== 1'b0 || b_clr_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done got=%b%b%b exp=000", ifa.clr_busy_o, ifa.clr_done_o, b_clr_done); end
  endtask

  task automatic test_rv32e();
    int n;
    idle();
    ifc.wr_en_i = 1'b1; ifc.wr_addr_i = 4'd15; ifc.wr_data_i = 32'h0F0F1234;
    tick();
    idle();
    ifc.rd_addr_i = {4'd15, 4'd15};
    #2;
    checks++; if (ifc.rd_data_o !== {2{32'h0F0F1234}}) begin errors++; $display("FAIL e_x15 got=%h exp=0f0f1234 x2", ifc.rd_data_o); end
    ifc.clr_req_i = 1'b1;
    tick();
    ifc.clr_req_i = 1'b0;
    n = 0;
    while (n < 50) begin
      #1;
      if (!ifc.clr_busy_o) break;
      n++;
      tick();
    end
    checks++; if (n != 15) begin errors++; $display("FAIL e_sweep_len got=%0d exp=15", n); end
    checks++; if (ifc.clr_done_o !== 1'b1) begin errors++; $display("FAIL e_sweep_done got=%b exp=1", ifc.clr_done_o); end
    tick();
    #1;
    checks++; if (ifc.rd_data_o !== 64'h0 || ifc.clr_done_o !== 1'b0) begin errors++; $display("FAIL e_after got=%h/%b exp=0/0", ifc.rd_data_o, ifc.clr_done_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_dual_write();
    test_busy();
    test_random();
    test_sweep();
    test_reset_mid_sweep();
    test_rv32e();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
